// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Parametrised raster timing generator. It walks a horizontal pixel counter
//   and a vertical line counter through active / front porch / sync / back
//   porch, and produces sync, blanking, pixel coordinates and per-line and
//   per-frame event pulses. One pixel is consumed for each cycle where
//   i_pix_stb is high. Everything else runs on the system clock.
//
// Optional feature:
//   VGA_FRAME_CNT_EN - when defined, adds a 16-bit frame counter output
//                      (o_frame) that advances together with o_screenend.
//
// Ports:
//   i_clk         system clock
//   i_rst_n       synchronous, active-low reset
//   i_pix_stb     pixel-advance qualifier (single-cycle pulse or held high)
//   o_hs          horizontal sync, HS_POL level while asserted
//   o_vs          vertical sync, VS_POL level while asserted
//   o_blanking    high outside the visible region
//   o_active      high inside the visible region
//   o_line_start  one-cycle pulse when the first pixel of a line is entered
//   o_screenend   one-cycle pulse when the last pixel of a frame is entered
//   o_animate     one-cycle pulse when the first blanked line is entered
//   o_x           visible pixel column, 0 while horizontally blanked
//   o_y           visible line, 0 while vertically blanked
//   o_frame       frame counter (VGA_FRAME_CNT_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   XW       = 10,
  parameter int   YW       = 9,
  parameter int   CW       = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pix_stb,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_blanking,
  output logic          o_active,
  output logic          o_line_start,
  output logic          o_screenend,
  output logic          o_animate,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]   o_frame
`endif
);

  // -------------------------------------------------------------------------
  // Derived geometry. All boundaries are pre-cast to the counter width so
  // the comparisons below are width-clean.
  // -------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);

  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // Raster position currently presented on the outputs.
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;

  // Position the raster moves to if this cycle carries a strobe.
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;

  // Output values decoded from the next position.
  logic          hs_nxt;
  logic          vs_nxt;
  logic          h_vis_nxt;
  logic          v_vis_nxt;
  logic          active_nxt;
  logic          line_start_nxt;
  logic          screenend_nxt;
  logic          animate_nxt;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;

  // Next-position arithmetic: the line counter advances only when the pixel
  // counter wraps, and both wrap together on the last pixel of the frame.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      if (v_cnt == V_LAST) begin
        v_nxt = '0;
      end else begin
        v_nxt = v_cnt + CNT_ONE;
      end
    end else begin
      h_nxt = h_cnt + CNT_ONE;
    end
  end

  // Decode the next position rather than the current one so that the
  // registered outputs line up with the counters after the same edge.
  always_comb begin
    h_vis_nxt      = (h_nxt < H_ACT_END);
    v_vis_nxt      = (v_nxt < V_ACT_END);
    active_nxt     = h_vis_nxt && v_vis_nxt;
    hs_nxt         = ((h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END)) ? HS_POL : ~HS_POL;
    vs_nxt         = ((v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END)) ? VS_POL : ~VS_POL;
    x_nxt          = h_vis_nxt ? h_nxt[XW-1:0] : '0;
    y_nxt          = v_vis_nxt ? v_nxt[YW-1:0] : '0;
    line_start_nxt = (h_nxt == '0);
    screenend_nxt  = (h_nxt == H_LAST) && (v_nxt == V_LAST);
    animate_nxt    = (h_nxt == '0) && (v_nxt == V_ACT_END);
  end

  // Raster counters. Reset wins over the strobe; without a strobe the
  // position simply holds.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_pix_stb) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Level outputs (sync, blanking, coordinates) only change on a strobe.
  // Reset values are exactly the decode of position (0,0).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_hs       <= ~HS_POL;
      o_vs       <= ~VS_POL;
      o_blanking <= 1'b0;
      o_active   <= 1'b1;
      o_x        <= '0;
      o_y        <= '0;
    end else if (i_pix_stb) begin
      o_hs       <= hs_nxt;
      o_vs       <= vs_nxt;
      o_blanking <= ~active_nxt;
      o_active   <= active_nxt;
      o_x        <= x_nxt;
      o_y        <= y_nxt;
    end
  end

  // Event pulses are cleared on every cycle without a strobe, so a pulse is
  // one system clock wide even when the strobe is sparse. With the strobe
  // held high the position moves every cycle, which also keeps them narrow.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_line_start <= 1'b1;
      o_screenend  <= 1'b0;
      o_animate    <= 1'b0;
    end else if (i_pix_stb) begin
      o_line_start <= line_start_nxt;
      o_screenend  <= screenend_nxt;
      o_animate    <= animate_nxt;
    end else begin
      o_line_start <= 1'b0;
      o_screenend  <= 1'b0;
      o_animate    <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Frame counter steps on the same edge that raises o_screenend and wraps
  // silently at 16 bits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_frame <= '0;
    end else if (i_pix_stb && screenend_nxt) begin
      o_frame <= o_frame + 16'd1;
    end
  end
`endif

endmodule
